tree_loader: RTL and testbench

TREE_LOADER -- requirements
Module: tree_loader

---
 rtl/tree_loader_if.sv | 55 +++++
 rtl/tree_loader.sv | 202 ++++++++++++++++++++
 tb/tb_tree_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_loader_if.sv
// tree_loader_if: record stream, evaluator write bus,
// evaluator result inputs and result handshake.
interface tree_loader_if #(
  parameter int W_ADDR   = 10,
  parameter int W_N_DATA = 12,
  parameter int W_C_DATA = 10,
  parameter int W_REWARD = 12,
  parameter int W_ACTION = 3
) ();
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_type;
  logic [W_ADDR-1:0]   in_addr;
  logic [W_N_DATA-1:0] in_data;
  logic                in_last;
  logic                mem_par;
  logic                mem_rew;
  logic                mem_act;
  logic                mem_weight;
  logic                conf_nodes;
  logic [W_ADDR-1:0]   mem_addr;
  logic [W_N_DATA-1:0] mem_data;
  logic [W_C_DATA-1:0] conf_data;
  logic                eval_start;
  logic                exp_change;
  logic [W_REWARD-1:0] exp;
  logic [W_ACTION-1:0] act;
  logic                res_valid;
  logic                res_ready;
  logic [W_REWARD-1:0] res_exp;
  logic [W_ACTION-1:0] res_act;
  logic                res_timeout;
  logic                err_type;
  logic                err_addr;
  logic                err_clr;
  logic                busy;

  modport slave (
    input  in_valid, in_type, in_addr, in_data, in_last,
    input  exp_change, exp, act, res_ready, err_clr,
    output in_ready, mem_par, mem_rew, mem_act, mem_weight,
    output conf_nodes, mem_addr, mem_data, conf_data,
    output eval_start, res_valid, res_exp, res_act,
    output res_timeout, err_type, err_addr, busy
  );

  modport master (
    output in_valid, in_type, in_addr, in_data, in_last,
    output exp_change, exp, act, res_ready, err_clr,
    input  in_ready, mem_par, mem_rew, mem_act, mem_weight,
    input  conf_nodes, mem_addr, mem_data, conf_data,
    input  eval_start, res_valid, res_exp, res_act,
    input  res_timeout, err_type, err_addr, busy
  );
endinterface

// File: rtl/tree_loader.sv
// tree_loader: streams tree records into the evaluator,
// restarts it and returns the evaluated reward/action.
module tree_loader #(
  parameter int W_ADDR   = 10,
  parameter int W_N_DATA = 12,
  parameter int W_C_DATA = 10,
  parameter int W_REWARD = 12,
  parameter int W_ACTION = 3,
  parameter int TIMEOUT  = 64
) (
  input logic         clk,
  input logic         rst,
  tree_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE
  } state_t;

  localparam int W_CMP  = (W_ADDR > W_C_DATA) ? W_ADDR : W_C_DATA;
  localparam int W_WCNT = $clog2(TIMEOUT + 1);
  localparam logic [W_WCNT-1:0] WCNT_MAX = W_WCNT'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_rdy;
  logic                r_busy;
  logic                r_pend;
  logic                r_eval;
  logic [W_WCNT-1:0]   r_wcnt;
  logic                r_res_valid;
  logic [W_REWARD-1:0] r_res_exp;
  logic [W_ACTION-1:0] r_res_act;
  logic                r_res_to;
  logic [W_C_DATA-1:0] r_nodes;
  logic                r_par;
  logic                r_rew;
  logic                r_act;
  logic                r_wgt;
  logic                r_conf;
  logic [W_ADDR-1:0]   r_mem_addr;
  logic [W_N_DATA-1:0] r_mem_data;
  logic [W_C_DATA-1:0] r_conf_data;
  logic                r_err_type;
  logic                r_err_addr;

  logic w_acc;
  logic w_is_conf;
  logic w_is_par;
  logic w_is_rew;
  logic w_is_act;
  logic w_is_wgt;
  logic w_is_ill;
  logic w_addr_ok;
  logic w_conf_ok;
  logic w_node_ok;
  logic w_set_type;
  logic w_set_addr;

  assign w_acc     = bus.in_valid && r_rdy;
  assign w_is_conf = (bus.in_type == 3'd0);
  assign w_is_par  = (bus.in_type == 3'd1);
  assign w_is_rew  = (bus.in_type == 3'd2);
  assign w_is_act  = (bus.in_type == 3'd3);
  assign w_is_wgt  = (bus.in_type == 3'd4);
  assign w_is_ill  = (bus.in_type > 3'd4);
  assign w_addr_ok = W_CMP'(bus.in_addr) < W_CMP'(r_nodes);
  assign w_conf_ok = w_is_conf && (bus.in_data[W_C_DATA-1:0] != '0);
  assign w_node_ok = !w_is_conf && !w_is_ill && w_addr_ok;

  assign w_set_type = w_acc && w_is_ill;
  assign w_set_addr = w_acc && ((w_is_conf && !w_conf_ok)
                   || (!w_is_conf && !w_is_ill && !w_addr_ok));

  // one-cycle write strobes and registered write bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par       <= 1'b0;
      r_rew       <= 1'b0;
      r_act       <= 1'b0;
      r_wgt       <= 1'b0;
      r_conf      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_conf_data <= '0;
      r_nodes     <= '0;
    end else begin
      r_par  <= w_acc && w_is_par && w_node_ok;
      r_rew  <= w_acc && w_is_rew && w_node_ok;
      r_act  <= w_acc && w_is_act && w_node_ok;
      r_wgt  <= w_acc && w_is_wgt && w_node_ok;
      r_conf <= w_acc && w_conf_ok;
      if (w_acc && w_conf_ok) begin
        r_conf_data <= bus.in_data[W_C_DATA-1:0];
        r_nodes     <= bus.in_data[W_C_DATA-1:0];
      end
      if (w_acc && w_node_ok) begin
        r_mem_addr <= bus.in_addr;
        r_mem_data <= bus.in_data;
      end
    end
  end

  // sticky error flags; a new error beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_type <= 1'b0;
      r_err_addr <= 1'b0;
    end else begin
      if (w_set_type)      r_err_type <= 1'b1;
      else if (bus.err_clr) r_err_type <= 1'b0;
      if (w_set_addr)      r_err_addr <= 1'b1;
      else if (bus.err_clr) r_err_addr <= 1'b0;
    end
  end

  // control FSM: load, restart evaluator, wait, hand back result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_eval      <= 1'b0;
      r_wcnt      <= '0;
      r_res_valid <= 1'b0;
      r_res_exp   <= '0;
      r_res_act   <= '0;
      r_res_to    <= 1'b0;
    end else begin
      r_eval <= 1'b0;
      unique case (r_state)
        S_IDLE, S_LOAD: begin
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_state <= S_START;
            r_eval  <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_rdy <= 1'b1;
            if (w_acc) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
              if (bus.in_last) begin
                r_pend <= 1'b1;
                r_rdy  <= 1'b0;
              end
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_wcnt  <= '0;
        end
        S_WAIT: begin
          if (bus.exp_change) begin
            r_res_exp   <= bus.exp;
            r_res_act   <= bus.act;
            r_res_to    <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_wcnt == WCNT_MAX) begin
            r_res_exp   <= '0;
            r_res_act   <= '0;
            r_res_to    <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + W_WCNT'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_rdy;
  assign bus.mem_par     = r_par;
  assign bus.mem_rew     = r_rew;
  assign bus.mem_act     = r_act;
  assign bus.mem_weight  = r_wgt;
  assign bus.conf_nodes  = r_conf;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data    = r_mem_data;
  assign bus.conf_data   = r_conf_data;
  assign bus.eval_start  = r_eval;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_exp     = r_res_exp;
  assign bus.res_act     = r_res_act;
  assign bus.res_timeout = r_res_to;
  assign bus.err_type    = r_err_type;
  assign bus.err_addr    = r_err_addr;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_tree_loader.sv
// tb_tree_loader: directed checks of loading, errors,
// timeout, result back-pressure and reset abort.
module tb_tree_loader;

  typedef struct packed {
    logic [2:0]  t;
    logic [9:0]  a;
    logic [11:0] d;
  } rec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  rec_t q[$];

  tree_loader_if bus ();

  tree_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] strb();
    return {bus.conf_nodes, bus.mem_par, bus.mem_rew,
            bus.mem_act, bus.mem_weight};
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({bus.in_ready, strb(), bus.eval_start, bus.res_valid,
                bus.res_timeout, bus.busy, bus.err_type, bus.err_addr,
                bus.mem_addr, bus.mem_data, bus.conf_data,
                bus.res_exp, bus.res_act});
  endfunction

  function automatic logic [63:0] res_vec();
    return 64'({bus.res_valid, bus.res_timeout, bus.res_act,
                bus.res_exp});
  endfunction

  task automatic drive(input logic v, input logic [2:0] t,
                       input logic [9:0] a, input logic [11:0] d,
                       input logic l);
    bus.in_valid = v;
    bus.in_type  = t;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic chk_rec(input string tag, input rec_t r);
    logic [4:0] e;
    case (r.t)
      3'd0:    e = 5'b10000;
      3'd1:    e = 5'b01000;
      3'd2:    e = 5'b00100;
      3'd3:    e = 5'b00010;
      3'd4:    e = 5'b00001;
      default: e = 5'b00000;
    endcase
    chk({tag, " strobe"}, 64'(strb()), 64'(e));
    if (r.t == 3'd0)
      chk({tag, " conf_data"}, 64'(bus.conf_data), 64'(r.d[9:0]));
    else
      chk({tag, " bus"}, 64'({bus.mem_addr, bus.mem_data}),
          64'({r.a, r.d}));
  endtask

  logic [11:0] rew_tbl [7];
  int          early;
  rec_t        r1;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    bus.exp_change = 1'b0;
    bus.exp        = '0;
    bus.act        = '0;
    bus.res_ready  = 1'b0;
    bus.err_clr    = 1'b0;
    #2 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset outputs", all_out(), 64'd0);
    @(negedge clk);
    chk("reset held", all_out(), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy after release", 64'(bus.in_ready), 64'd1);
    chk("busy idle", 64'(bus.busy), 64'd0);

    // A: seven-node tree
    rew_tbl = '{12'd0, 12'd0, 12'hFF6, 12'd0, 12'h064, 12'hFCE, 12'h00A};
    q.push_back('{3'd0, 10'd0, 12'd7});
    for (int i = 0; i < 7; i++)
      q.push_back('{3'd1, 10'(i), (i >= 4) ? 12'd1 : 12'd0});
    for (int i = 0; i < 7; i++)
      q.push_back('{3'd2, 10'(i), rew_tbl[i]});
    for (int i = 0; i < 7; i++)
      q.push_back('{3'd3, 10'(i), 12'(i)});
    for (int i = 0; i < 7; i++)
      q.push_back('{3'd4, 10'(i), (i == 6) ? 12'd127 : 12'd64});
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) chk_rec($sformatf("A rec%0d", i - 1), q[i - 1]);
      drive(1'b1, q[i].t, q[i].a, q[i].d, i == q.size() - 1);
      @(negedge clk);
    end
    chk_rec("A rec28", q[q.size() - 1]);
    chk("A rdy low on last strobe", 64'(bus.in_ready), 64'd0);
    chk("A busy load", 64'(bus.busy), 64'd1);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    @(negedge clk);
    chk("A eval_start", 64'(bus.eval_start), 64'd1);
    chk("A no strobe after last", 64'(strb()), 64'd0);
    bus.exp_change = 1'b1;
    bus.exp        = 12'd99;
    bus.act        = 3'd5;
    @(negedge clk);
    chk("A eval_start single", 64'(bus.eval_start), 64'd0);
    chk("A no early result", 64'(bus.res_valid), 64'd0);
    bus.exp = 12'd45;
    bus.act = 3'd1;
    @(negedge clk);
    chk("A result", res_vec(), 64'({1'b1, 1'b0, 3'd1, 12'd45}));
    chk("A no errors", 64'({bus.err_type, bus.err_addr}), 64'd0);
    bus.exp_change = 1'b0;
    bus.res_ready  = 1'b1;
    @(negedge clk);
    chk("A handshake", 64'({bus.res_valid, bus.in_ready, bus.busy}),
        64'b010);
    bus.res_ready = 1'b0;

    // B: bad address, reuse of node count, timeout, back-pressure
    drive(1'b1, 3'd1, 10'd7, 12'd1, 1'b0);
    @(negedge clk);
    chk("B drop strobe", 64'(strb()), 64'd0);
    chk("B err_addr", 64'(bus.err_addr), 64'd1);
    drive(1'b1, 3'd1, 10'd3, 12'd1, 1'b1);
    @(negedge clk);
    r1 = '{3'd1, 10'd3, 12'd1};
    chk_rec("B second tree", r1);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    @(negedge clk);
    chk("B eval_start", 64'(bus.eval_start), 64'd1);
    early = 0;
    repeat (64) begin
      @(negedge clk);
      if (bus.res_valid) early++;
    end
    chk("B no early timeout", 64'(early), 64'd0);
    @(negedge clk);
    chk("B timeout result", res_vec(), 64'({1'b1, 1'b1, 3'd0, 12'd0}));
    chk("B err_addr held", 64'(bus.err_addr), 64'd1);
    bus.err_clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk($sformatf("B hold%0d", i),
          64'({res_vec(), bus.in_ready, bus.busy}),
          64'({1'b1, 1'b1, 3'd0, 12'd0, 1'b0, 1'b1}));
    end
    chk("B err_clr", 64'(bus.err_addr), 64'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("B handshake", 64'({bus.res_valid, bus.in_ready, bus.busy}),
        64'b010);
    bus.res_ready = 1'b0;

    // C: illegal type with last; error beats same-cycle clear
    drive(1'b1, 3'd6, 10'd0, 12'd0, 1'b1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    chk("C drop strobe", 64'(strb()), 64'd0);
    chk("C err_type", 64'(bus.err_type), 64'd1);
    chk("C rdy low", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("C eval_start", 64'(bus.eval_start), 64'd1);
    @(negedge clk);
    bus.exp_change = 1'b1;
    bus.exp        = 12'h800;
    bus.act        = 3'd7;
    @(negedge clk);
    chk("C result", res_vec(), 64'({1'b1, 1'b0, 3'd7, 12'h800}));
    bus.exp_change = 1'b0;
    bus.res_ready  = 1'b1;
    @(negedge clk);
    chk("C handshake", 64'(bus.res_valid), 64'd0);
    bus.res_ready = 1'b0;

    // D: reset during WAIT aborts everything
    drive(1'b1, 3'd4, 10'd0, 12'd5, 1'b1);
    @(negedge clk);
    r1 = '{3'd4, 10'd0, 12'd5};
    chk_rec("D weight", r1);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    @(negedge clk);
    chk("D eval_start", 64'(bus.eval_start), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.exp_change = 1'b1;
    bus.exp        = 12'd33;
    bus.act        = 3'd2;
    #1;
    chk("D async reset", all_out(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("D rdy after release", 64'(bus.in_ready), 64'd1);
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) early++;
    end
    chk("D no result after abort", 64'(early), 64'd0);
    bus.exp_change = 1'b0;

    // E: node count back to 0; conf 0 rejected
    drive(1'b1, 3'd1, 10'd0, 12'd0, 1'b0);
    @(negedge clk);
    chk("E drop after reset", 64'(strb()), 64'd0);
    chk("E err_addr", 64'(bus.err_addr), 64'd1);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    bus.err_clr = 1'b1;
    @(negedge clk);
    chk("E err cleared", 64'(bus.err_addr), 64'd0);
    bus.err_clr = 1'b0;
    drive(1'b1, 3'd0, 10'd0, 12'd0, 1'b1);
    @(negedge clk);
    chk("E conf0 drop", 64'(strb()), 64'd0);
    chk("E conf0 err", 64'(bus.err_addr), 64'd1);
    drive(1'b0, 3'd0, 10'd0, 12'd0, 1'b0);
    @(negedge clk);
    chk("E eval_start", 64'(bus.eval_start), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
